// File: rtl/ssd_scan_if.sv
// ssd_scan_if -- bundle between the game logic and the seven-segment scanner.
//   master : game-side view; drives load/hex_in/dp_in/dig_en and observes the pins
//   slave  : scanner-side view; samples the load request and drives the pins
// Signals:
//   load       1-cycle strobe capturing hex_in/dp_in/dig_en into the pending buffer
//   hex_in     16-bit value, digit0=[15:12] (leftmost) .. digit3=[3:0]
//   dp_in      per-digit decimal point request, 1=lit
//   dig_en     per-digit enable, 1=shown
//   seg        active-low segments, seg[0]=a .. seg[6]=g
//   dp         active-low decimal point
//   an         active-low anode enables, an[0]=leftmost
//   frame_done 1-cycle pulse after each frame boundary
interface ssd_scan_if;
  logic        load;
  logic [15:0] hex_in;
  logic [3:0]  dp_in;
  logic [3:0]  dig_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  modport master (
    output load, hex_in, dp_in, dig_en,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  load, hex_in, dp_in, dig_en,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl -- four-digit common-anode seven-segment scan controller.
// Time-multiplexes the shared segment bus over an[3:0]. A 16-bit hex value plus
// per-digit enable and DP bits are double-buffered: load writes the pending
// buffer, and pending is promoted to active only at a frame boundary.
// Ports:
//   clk    single clock, all state on posedge
//   reset  synchronous, active-high
//   bus    ssd_scan_if.slave (load/hex_in/dp_in/dig_en in, seg/dp/an/frame_done out)
// Parameters:
//   REFRESH_DIV  cycles per digit slot (>= 2)
//   DEAD_CYCLES  blanked cycles at the start of each slot (< REFRESH_DIV)
// Configuration macro:
//   SSD_DEADTIME_EN  when defined, the first DEAD_CYCLES pin-cycles of every slot
//                    are blanked (anti-ghosting); otherwise DEAD_CYCLES is ignored.
module ssd_scan_ctrl #(
  parameter int REFRESH_DIV = 16,
  parameter int DEAD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  ssd_scan_if.slave  bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] SLOT_TC = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_TC = CNT_W'(DEAD_CYCLES);

`ifdef SSD_DEADTIME_EN
  localparam logic DT_EN = 1'b1;
`else
  localparam logic DT_EN = 1'b0;
`endif

  // Active-low {g..a} pattern for one hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b1000000;
      4'h1:    pat = 7'b1111001;
      4'h2:    pat = 7'b0100100;
      4'h3:    pat = 7'b0110000;
      4'h4:    pat = 7'b0011001;
      4'h5:    pat = 7'b0010010;
      4'h6:    pat = 7'b0000010;
      4'h7:    pat = 7'b1111000;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0010000;
      4'hA:    pat = 7'b0001000;
      4'hB:    pat = 7'b0000011;
      4'hC:    pat = 7'b1000110;
      4'hD:    pat = 7'b0100001;
      4'hE:    pat = 7'b0000110;
      4'hF:    pat = 7'b0001110;
      default: pat = 7'h7F;
    endcase
    return pat;
  endfunction

  logic [CNT_W-1:0] slot_cnt_r;
  logic [1:0]       idx_r;
  logic [15:0]      act_hex_r, pend_hex_r;
  logic [3:0]       act_dp_r,  pend_dp_r;
  logic [3:0]       act_en_r,  pend_en_r;
  logic             pend_r;

  logic [6:0] seg_r;
  logic       dp_r;
  logic [3:0] an_r;
  logic       frame_done_r;

  logic       tc_s;
  logic       boundary_s;
  logic [3:0] nib_s;
  logic       show_s;
  logic [6:0] seg_nxt_s;
  logic       dp_nxt_s;
  logic [3:0] an_nxt_s;

  assign tc_s       = (slot_cnt_r == SLOT_TC);
  assign boundary_s = tc_s && (idx_r == 2'd3);

  // Slot counter and digit index: the index steps once per slot and wraps every frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt_r <= '0;
      idx_r      <= 2'd0;
    end else if (tc_s) begin
      slot_cnt_r <= '0;
      idx_r      <= idx_r + 2'd1;
    end else begin
      slot_cnt_r <= slot_cnt_r + CNT_W'(1);
    end
  end

  // Double buffer: promotion uses the old pending value even when a load
  // lands on the boundary cycle; that load then stays pending for next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_hex_r  <= 16'h0000;
      act_dp_r   <= 4'h0;
      act_en_r   <= 4'h0;
      pend_hex_r <= 16'h0000;
      pend_dp_r  <= 4'h0;
      pend_en_r  <= 4'h0;
      pend_r     <= 1'b0;
    end else begin
      if (boundary_s && pend_r) begin
        act_hex_r <= pend_hex_r;
        act_dp_r  <= pend_dp_r;
        act_en_r  <= pend_en_r;
      end
      if (bus.load) begin
        pend_hex_r <= bus.hex_in;
        pend_dp_r  <= bus.dp_in;
        pend_en_r  <= bus.dig_en;
        pend_r     <= 1'b1;
      end else if (boundary_s) begin
        pend_r <= 1'b0;
      end
    end
  end

  // Next pin values for the current digit; blanked if disabled or in dead time.
  always_comb begin
    nib_s = 4'h0;
    case (idx_r)
      2'd0:    nib_s = act_hex_r[15:12];
      2'd1:    nib_s = act_hex_r[11:8];
      2'd2:    nib_s = act_hex_r[7:4];
      2'd3:    nib_s = act_hex_r[3:0];
      default: nib_s = 4'h0;
    endcase
    show_s = act_en_r[idx_r] && !(DT_EN && (slot_cnt_r < DEAD_TC));
    if (show_s) begin
      an_nxt_s  = ~(4'b0001 << idx_r);
      seg_nxt_s = seg_decode(nib_s);
      dp_nxt_s  = ~act_dp_r[idx_r];
    end else begin
      an_nxt_s  = 4'b1111;
      seg_nxt_s = 7'h7F;
      dp_nxt_s  = 1'b1;
    end
  end

  // Pin registers: every output comes straight from a flop, so an cannot glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_r         <= 4'b1111;
      seg_r        <= 7'h7F;
      dp_r         <= 1'b1;
      frame_done_r <= 1'b0;
    end else begin
      an_r         <= an_nxt_s;
      seg_r        <= seg_nxt_s;
      dp_r         <= dp_nxt_s;
      frame_done_r <= boundary_s;
    end
  end

  assign bus.an         = an_r;
  assign bus.seg        = seg_r;
  assign bus.dp         = dp_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl with REFRESH_DIV=4, DEAD_CYCLES=1 (16-cycle frame).
module tb_ssd_scan_ctrl;
  localparam int RD    = 4;
  localparam int DC    = 1;
  localparam int FRAME = 4 * RD;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ssd_scan_if bus();

  ssd_scan_ctrl #(.REFRESH_DIV(RD), .DEAD_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int fd_seen  = 0;

  // Reference model: display state as plain values, time as edge count since reset.
  int          m_t;
  logic [15:0] m_act_hex, m_pen_hex;
  logic [3:0]  m_act_dp, m_act_en, m_pen_dp, m_pen_en;
  logic        m_pend;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_fd;
  logic [6:0]  dec [16];

  typedef struct {
    logic        ld;
    logic [15:0] hex;
    logic [3:0]  dpi;
    logic [3:0]  en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        fd;
  } vec_t;
  vec_t vt [32];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic ld, input logic [15:0] h,
                            input logic [3:0] d, input logic [3:0] e);
    int dg, pos;
    logic show, boundary;
    logic [3:0] nib;
    if (r) begin
      m_t = 0;
      m_act_hex = 16'h0; m_act_dp = 4'h0; m_act_en = 4'h0;
      m_pen_hex = 16'h0; m_pen_dp = 4'h0; m_pen_en = 4'h0;
      m_pend = 1'b0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      dg  = (m_t / RD) % 4;
      pos = m_t % RD;
      show = m_act_en[dg];
`ifdef SSD_DEADTIME_EN
      if (pos < DC) show = 1'b0;
`endif
      nib = 4'((m_act_hex >> (4 * (3 - dg))) & 16'h000F);
      if (show) begin
        e_an  = 4'hF & ~(4'(1) << dg);
        e_seg = dec[nib];
        e_dp  = ~m_act_dp[dg];
      end else begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end
      boundary = ((m_t % FRAME) == FRAME - 1);
      e_fd = boundary;
      if (boundary && m_pend) begin
        m_act_hex = m_pen_hex; m_act_dp = m_pen_dp; m_act_en = m_pen_en;
      end
      if (ld) begin
        m_pen_hex = h; m_pen_dp = d; m_pen_en = e; m_pend = 1'b1;
      end else if (boundary) begin
        m_pend = 1'b0;
      end
      m_t++;
    end
  endtask

  // One clock: drive at negedge, model the posedge, compare at the next negedge.
  task automatic cyc(input logic r, input logic ld, input logic [15:0] h,
                     input logic [3:0] d, input logic [3:0] e);
    reset = r; bus.load = ld; bus.hex_in = h; bus.dp_in = d; bus.dig_en = e;
    @(posedge clk);
    model_edge(r, ld, h, d, e);
    @(negedge clk);
    check("an",  int'(bus.an),         int'(e_an));
    check("seg", int'(bus.seg),        int'(e_seg));
    check("dp",  int'(bus.dp),         int'(e_dp));
    check("fd",  int'(bus.frame_done), int'(e_fd));
    if (bus.frame_done) fd_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
  endtask

  task automatic sync_frame();
    while ((m_t % FRAME) != 0) cyc(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
  endtask

  logic [3:0] an_pat  [4];
  logic [6:0] seg_pat [4];

  initial begin
    dec = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    an_pat  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_pat = '{7'b1111001, 7'b0100100, 7'b0001000, 7'b0000000};
    // Table: load 12A8 at the first frame edge; blank frame, then the pattern.
    for (int i = 0; i < 32; i++) begin
      vt[i].ld  = (i == 0);
      vt[i].hex = (i == 0) ? 16'h12A8 : 16'h0000;
      vt[i].dpi = 4'h0;
      vt[i].en  = (i == 0) ? 4'hF : 4'h0;
      vt[i].fd  = ((i % 16) == 15);
      vt[i].dp  = 1'b1;
      if (i < 16) begin
        vt[i].an = 4'hF; vt[i].seg = 7'h7F;
      end else begin
        vt[i].an = an_pat[(i - 16) / 4]; vt[i].seg = seg_pat[(i - 16) / 4];
`ifdef SSD_DEADTIME_EN
        if ((i % 4) == 0) begin
          vt[i].an = 4'hF; vt[i].seg = 7'h7F;
        end
`endif
      end
    end

    bus.load = 1'b0; bus.hex_in = 16'h0; bus.dp_in = 4'h0; bus.dig_en = 4'h0;
    m_t = 0; m_pend = 1'b0;

    // Reset state
    cyc(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    cyc(1'b1, 1'b1, 16'hFFFF, 4'hF, 4'hF);
    check("rst_an",  int'(bus.an),  32'hF);
    check("rst_seg", int'(bus.seg), 32'h7F);
    check("rst_dp",  int'(bus.dp),  1);

    // Idle: blank display, frame_done every 16 cycles
    fd_seen = 0;
    idle(64);
    check("fd_count_64", fd_seen, 4);

    // Table-driven 12A8 frame sequence
    sync_frame();
    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, vt[i].ld, vt[i].hex, vt[i].dpi, vt[i].en);
      check("tbl_an",  int'(bus.an),         int'(vt[i].an));
      check("tbl_seg", int'(bus.seg),        int'(vt[i].seg));
      check("tbl_dp",  int'(bus.dp),         int'(vt[i].dp));
      check("tbl_fd",  int'(bus.frame_done), int'(vt[i].fd));
    end

    // C0DE with digits 0 and 2 enabled, DP on digit 2
    sync_frame();
    cyc(1'b0, 1'b1, 16'hC0DE, 4'b0100, 4'b0101);
    idle(17);
    check("c0de_d0_an",  int'(bus.an),  32'b1110);
    check("c0de_d0_seg", int'(bus.seg), 32'b1000110);
    idle(4);
    check("c0de_d1_an",  int'(bus.an),  32'hF);
    check("c0de_d1_seg", int'(bus.seg), 32'h7F);
    idle(4);
    check("c0de_d2_an",  int'(bus.an),  32'b1011);
    check("c0de_d2_seg", int'(bus.seg), 32'b0100001);
    check("c0de_d2_dp",  int'(bus.dp),  0);
    idle(4);
    check("c0de_d3_an",  int'(bus.an),  32'hF);

    // Two loads in a frame plus one on the boundary cycle
    sync_frame();
    idle(2);
    cyc(1'b0, 1'b1, 16'h1111, 4'h0, 4'hF);
    idle(2);
    cyc(1'b0, 1'b1, 16'h2222, 4'h0, 4'hF);
    idle(9);
    cyc(1'b0, 1'b1, 16'h3333, 4'h0, 4'hF);
    idle(2);
    check("dbl_2222_seg", int'(bus.seg), 32'b0100100);
    idle(16);
    check("dbl_3333_seg", int'(bus.seg), 32'b0110000);
    check("dbl_3333_an",  int'(bus.an),  32'b1110);

    // Reset (with a simultaneous load) while digit 2 is on the pins
    sync_frame();
    idle(10);
    check("pre_rst_an", int'(bus.an), 32'b1011);
    cyc(1'b1, 1'b1, 16'h5555, 4'hF, 4'hF);
    check("mid_rst_an",  int'(bus.an),         32'hF);
    check("mid_rst_seg", int'(bus.seg),        32'h7F);
    check("mid_rst_fd",  int'(bus.frame_done), 0);
    idle(40);
    check("post_rst_blank", int'(bus.an), 32'hF);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      cyc(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 5) == 0),
          16'($urandom), 4'($urandom), 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
